// File: rtl/filter_drain.sv
// filter_drain: elastic FWFT output stage behind the non-stallable filter chain.
// Define FILTER_DRAIN_DROP_CNT_EN to add the saturating io_drop_count port.
module filter_drain #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   io_x_data,
  input  logic          io_x_valid,
  input  logic          io_x_parity,
  output logic [15:0]   io_y_data,
  output logic          io_y_parity,
  output logic          io_y_valid,
  input  logic          io_y_ready,
  output logic [AW:0]   io_count,
`ifdef FILTER_DRAIN_DROP_CNT_EN
  output logic [7:0]    io_drop_count,
`endif
  output logic          io_overflow
);

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          ovf;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign full = (cnt == (AW+1)'(DEPTH));
  assign pop  = (cnt != '0) & io_y_ready;
  assign push = io_x_valid & (~full | pop);
  assign drop = io_x_valid & ~push;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= {io_x_parity, io_x_data};
        wp      <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop)
        ovf <= 1'b1;
    end
  end

`ifdef FILTER_DRAIN_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

  assign io_drop_count = drop_cnt;
`endif

  assign io_y_data   = mem[rp][15:0];
  assign io_y_parity = mem[rp][16];
  assign io_y_valid  = (cnt != '0);
  assign io_count    = cnt;
  assign io_overflow = ovf;

endmodule

// File: tb/tb_filter_drain.sv
// tb_filter_drain: scoreboard bench for filter_drain.
// Driver pushes expected beats; negedge monitor pops and compares.
module tb_filter_drain;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] io_x_data = '0;
  logic        io_x_valid = 1'b0;
  logic        io_x_parity = 1'b0;
  logic [15:0] io_y_data;
  logic        io_y_parity;
  logic        io_y_valid;
  logic        io_y_ready = 1'b0;
  logic [2:0]  io_count;
  logic        io_overflow;
`ifdef FILTER_DRAIN_DROP_CNT_EN
  logic [7:0]  io_drop_count;
`endif

  filter_drain #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .io_x_data(io_x_data),
    .io_x_valid(io_x_valid),
    .io_x_parity(io_x_parity),
    .io_y_data(io_y_data),
    .io_y_parity(io_y_parity),
    .io_y_valid(io_y_valid),
    .io_y_ready(io_y_ready),
    .io_count(io_count),
`ifdef FILTER_DRAIN_DROP_CNT_EN
    .io_drop_count(io_drop_count),
`endif
    .io_overflow(io_overflow)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  logic [16:0] exp_q[$];
  int          mcnt = 0;
  int          ncnt = 0;
  bit          movf = 0;
  bit          novf = 0;
  int          mdrop = 0;
  int          ndrop = 0;
  bit          started = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // Model: FIFO of accepted beats, occupancy, sticky overflow, drop count.
  task automatic cycle(input bit v, input logic [15:0] d,
                       input bit p, input bit r);
    bit pop, push;
    io_x_valid  = v;
    io_x_data   = d;
    io_x_parity = p;
    io_y_ready  = r;
    pop  = (mcnt > 0) && r;
    push = v && ((mcnt < DEPTH) || pop);
    if (push) exp_q.push_back({p, d});
    ncnt  = mcnt + int'(push) - int'(pop);
    novf  = movf | (v & !push);
    ndrop = (v && !push && mdrop < 255) ? mdrop + 1 : mdrop;
    @(posedge clk);
    mcnt  = ncnt;
    movf  = novf;
    mdrop = ndrop;
    #1;
  endtask

  task automatic do_reset(input bit v);
    reset       = 1'b1;
    io_x_valid  = v;
    io_x_data   = 16'($urandom);
    io_x_parity = 1'($urandom);
    io_y_ready  = 1'($urandom);
    exp_q.delete();
    @(posedge clk);
    mcnt  = 0;
    movf  = 0;
    mdrop = 0;
    #1;
    reset      = 1'b0;
    io_x_valid = 1'b0;
    io_y_ready = 1'b0;
    @(negedge clk);
    check("rst_data", int'(io_y_data), 0);
    check("rst_parity", int'(io_y_parity), 0);
    #1;
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      check("y_valid", int'(io_y_valid), int'(mcnt > 0));
      check("count", int'(io_count), mcnt);
      check("overflow", int'(io_overflow), int'(movf));
`ifdef FILTER_DRAIN_DROP_CNT_EN
      check("drop_count", int'(io_drop_count), mdrop);
`endif
      if (io_y_valid) begin
        if (exp_q.size() == 0) begin
          check("head_missing", exp_q.size(), 1);
        end else begin
          check("head_data", int'(io_y_data), int'(exp_q[0][15:0]));
          check("head_parity", int'(io_y_parity), int'(exp_q[0][16]));
          if (io_y_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    started = 1;
    do_reset(0);

    // single beat, held
    cycle(1, 16'h1234, 1, 0);
    cycle(0, 16'h0, 0, 0);
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 1);

    // overfill with six beats, then drain
    for (int i = 1; i <= 6; i++) cycle(1, 16'(i), 1'(i), 0);
    for (int i = 0; i < 6; i++) cycle(0, 16'h0, 0, 1);

    // full with simultaneous push and pop
    do_reset(0);
    for (int i = 0; i < 4; i++) cycle(1, 16'h0050 + 16'(i), 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 16'h00A0 + 16'(i), 1'(i), 1);
    for (int i = 0; i < 6; i++) cycle(0, 16'h0, 0, 1);

    // back-to-back with wrap
    for (int i = 0; i < 10; i++) cycle(1, 16'h0C00 + 16'(i), 1'(i >> 1), 1);
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 1);

    // reset mid-stream with a beat present
    cycle(1, 16'h0BAD, 0, 0);
    cycle(1, 16'h0BAE, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 16'h00F0, 1, 0);
    do_reset(0);
    for (int i = 0; i < 3; i++) cycle(1, 16'h0D00 + 16'(i), 0, 0);
    do_reset(1);
    cycle(0, 16'h0, 0, 1);
    cycle(1, 16'h0E01, 1, 0);
    cycle(0, 16'h0, 0, 1);

    // long drop run for counter saturation
    for (int i = 0; i < 4; i++) cycle(1, 16'h0F00 + 16'(i), 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, 16'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 6; i++) cycle(0, 16'h0, 0, 1);

    // random traffic
    do_reset(0);
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0);
    for (int i = 0; i < 6; i++) cycle(0, 16'h0, 0, 1);

    check("leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/filter_drain.md
# filter_drain

Elastic output stage directly downstream of the `FilterBlock` chain. The filter chain emits one beat per valid cycle and cannot be stalled. This block captures each beat (`data`, `parity`) into a small first-word-fall-through FIFO and re-presents it on a ready/valid interface to a consumer that may stall. Beats that arrive while the FIFO is full are dropped and flagged, because backpressure cannot reach the filter.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `AW`, default `log2(DEPTH)`: pointer width; derived, not overridden.
- `clk` in 1: sole clock, all state on rising edge.
- `reset` in 1: synchronous reset, active-high.
- `io_x_data` in 16: beat data from filter `io_y_data`.
- `io_x_valid` in 1: beat present this cycle; no ready, cannot be stalled.
- `io_x_parity` in 1: parity/carry bit from filter `io_y_parity`.
- `io_y_data` out 16: head-entry data.
- `io_y_parity` out 1: head-entry parity bit.
- `io_y_valid` out 1: FIFO non-empty.
- `io_y_ready` in 1: consumer accepts the head entry this cycle.
- `io_count` out AW+1: occupancy, 0..DEPTH.
- `io_overflow` out 1: sticky; a beat was dropped since reset.
- `io_drop_count` out 8: present only with `FILTER_DRAIN_DROP_CNT_EN`.

## Operation
- Storage: DEPTH × 17-bit entries `{parity, data}`, write pointer `wp`, read pointer `rp` (AW bits, wrap modulo DEPTH), occupancy `cnt` (AW+1 bits).
- `pop = io_y_valid & io_y_ready`.
- `push = io_x_valid & (cnt != DEPTH | pop)`: a full FIFO accepts a beat in the same cycle it pops.
- `drop = io_x_valid & ~push`, i.e. valid while full with no pop.
- On push: `mem[wp] <= {io_x_parity, io_x_data}` and `wp <= wp+1`.
- On pop: `rp <= rp+1`.
- `cnt` changes by +1 on push only, −1 on pop only, and is unchanged on both or neither.
- Outputs:
  - `io_y_valid = (cnt != 0)`.
  - `io_y_data`/`io_y_parity = mem[rp]`, a combinational read (first-word fall-through).
  - `io_count = cnt`.
- `io_y_data` and `io_y_parity` are only meaningful while `io_y_valid`. The consumer must hold off acceptance until valid; `io_y_ready` while empty is ignored (no pop).
- Drop: the arriving beat is discarded, FIFO contents are unchanged, and `io_overflow <= 1`. The flag clears only on `reset`.
- Ordering: strict FIFO. Accepted beats exit in arrival order with no duplication.
- Pointer wrap: `wp`/`rp` roll from DEPTH−1 to 0. Full and empty are distinguished by `cnt`, never by pointer equality.

## Timing
- Reset, while `reset`=1 at an edge: `wp`=`rp`=`cnt`=0, all `mem` entries 0, `io_overflow`=0, `io_drop_count`=0.
- Outputs after reset: `io_y_valid`=0, `io_y_data`=0, `io_y_parity`=0, `io_count`=0.
- `reset` has priority over push, pop and drop in the same cycle. Reset mid-stream discards all stored beats, and the beat presented during the reset cycle is not captured.
- Latency: a beat pushed at edge N is visible on `io_y_*` with `io_y_valid`=1 in the cycle after edge N (1 cycle). There is no combinational path from `io_x_*` to `io_y_*`.
- `io_y_valid`, `io_count` and `io_overflow` are register-derived. Only `push`/`drop` depend combinationally on `io_y_ready`.
- Throughput: 1 beat/cycle sustained when `io_y_ready`=1 continuously, at any occupancy including full.

## Configuration
- `FILTER_DRAIN_DROP_CNT_EN` defined:
  - Adds port `io_drop_count[7:0]`.
  - Increments by 1 on each `drop` cycle and saturates at 255 (no wrap).
  - Cleared by `reset`.
- Not defined: the port and its counter do not exist. `io_overflow` behaviour is identical in both builds.

## Test plan
- Reset, then `io_x_valid`=1, `io_x_data`=0x1234, `io_x_parity`=1 for one cycle with `io_y_ready`=0 -> next cycle `io_y_valid`=1, `io_y_data`=0x1234, `io_y_parity`=1, `io_count`=1.
- DEPTH=4, `io_y_ready`=0, push 0x0001..0x0006 on consecutive cycles -> `io_count`=4, `io_overflow`=1 after the 5th beat. Then `io_y_ready`=1 -> outputs 0x0001, 0x0002, 0x0003, 0x0004, then `io_y_valid`=0. With the macro, `io_drop_count`=2.
- Fill to 4, then hold `io_x_valid`=1 and `io_y_ready`=1 for 8 cycles with data 0x00A0+i -> no drops, `io_count` stays 4, output order continuous.
- Ten back-to-back beats with `io_y_ready`=1 throughout (pointer wrap) -> each beat appears exactly 1 cycle after input, in order, with `io_count` ≤ 1.
- Fill to 3, assert `reset` for 1 cycle while `io_x_valid`=1 -> next cycle `io_count`=0, `io_y_valid`=0, `io_y_data`=0, `io_overflow`=0, and the reset-cycle beat is absent.
- Macro build: 300 drop cycles -> `io_drop_count`=255, `io_overflow`=1.
